// File: rtl/and_gate_selftest.sv
// On-board stimulus/checker for a two-input AND gate: sweeps all four input
// pairs, samples the synchronized gate output and reports pass/fail status.
module and_gate_selftest #(
    parameter int SETTLE_CYCLES = 4,
    parameter int LOOPS         = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             drv_in0,
    output logic             drv_in1,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec
);

    localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [7:0]       LOOP_LAST = 8'(LOOPS - 1);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [7:0]       loop_q, loop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [1:0]       drv_q, drv_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [3:0]       fail_q, fail_d;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        loop_d  = loop_q;
        cnt_d   = cnt_q;
        sync1_d = dut_out;
        sync2_d = sync1_q;
        drv_d   = drv_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d = DRIVE;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fail_d  = '0;
                    vec_d   = '0;
                    loop_d  = '0;
                end
            end
            DRIVE: begin
                drv_d   = vec_q;
                cnt_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SAMPLE: begin
                // Only vector 3 (both inputs high) should drive the output high.
                if (sync2_q != (vec_q[1] & vec_q[0])) begin
                    fail_d[vec_q] = 1'b1;
                    err_d         = sat_inc(err_q);
                end
                if (vec_q != 2'd3) begin
                    vec_d   = vec_q + 2'd1;
                    state_d = DRIVE;
                end else if (loop_q != LOOP_LAST) begin
                    loop_d  = loop_q + 8'd1;
                    vec_d   = '0;
                    state_d = DRIVE;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
                pass_d = (err_q == '0);
                drv_d  = '0;
                if (start) begin
                    state_d = DRIVE;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fail_d  = '0;
                    vec_d   = '0;
                    loop_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            loop_q  <= '0;
            cnt_q   <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            drv_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            loop_q  <= loop_d;
            cnt_q   <= cnt_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            drv_q   <= drv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    assign drv_in0   = drv_q[0];
    assign drv_in1   = drv_q[1];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule

// File: tb/tb_and_gate_selftest.sv
// Bench for and_gate_selftest: gate models drive dut_out, a queue holds the
// expected result of each run and monitors compare when done rises.
module tb_and_gate_selftest;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Instance A: defaults, gate model selected by mode.
    logic       rst, start, drv0_a, drv1_a, dut_out_a, busy_a, done_a, pass_a;
    logic [7:0] err_a;
    logic [3:0] fv_a;
    int         mode;

    // Instance B: narrow saturating counter, many loops, stuck-at-1 output.
    logic       rst_b, start_b, drv0_b, drv1_b, busy_b, done_b, pass_b;
    logic [3:0] err_b;
    logic [3:0] fv_b;

    always_comb begin
        case (mode)
            0:       dut_out_a = drv1_a & drv0_a;
            1:       dut_out_a = 1'b0;
            2:       dut_out_a = 1'b1;
            default: dut_out_a = drv1_a | drv0_a;
        endcase
    end

    and_gate_selftest u_a (
        .clk(clk), .rst(rst), .start(start),
        .drv_in0(drv0_a), .drv_in1(drv1_a), .dut_out(dut_out_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .fail_vec(fv_a)
    );

    and_gate_selftest #(.SETTLE_CYCLES(4), .LOOPS(10), .ERR_W(4)) u_b (
        .clk(clk), .rst(rst_b), .start(start_b),
        .drv_in0(drv0_b), .drv_in1(drv1_b), .dut_out(1'b1),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .fail_vec(fv_b)
    );

    typedef struct {
        logic       pass;
        int         err;
        logic [3:0] fv;
        int         lat;
        int         st;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    logic done_a_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done_a && !done_a_prev) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_done", 1, 0);
            end else begin
                e = q_a.pop_front();
                chk("a_pass", int'(pass_a), int'(e.pass));
                chk("a_err_count", int'(err_a), e.err);
                chk("a_fail_vec", int'(fv_a), int'(e.fv));
                chk("a_done_edge", cyc - e.st, e.lat);
            end
        end
        done_a_prev = done_a;
    end

    logic done_b_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done_b && !done_b_prev) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_done", 1, 0);
            end else begin
                e = q_b.pop_front();
                chk("b_pass", int'(pass_b), int'(e.pass));
                chk("b_err_count", int'(err_b), e.err);
                chk("b_fail_vec", int'(fv_b), int'(e.fv));
                chk("b_done_edge", cyc - e.st, e.lat);
            end
        end
        done_b_prev = done_b;
    end

    // One run on instance A; optionally checks the driven pairs and pulses
    // start again at relative edge pulse_rel while the run is busy.
    task automatic run_a(input int m, input logic ep, input int ee,
                         input logic [3:0] ef, input bit chk_drv, input int pulse_rel);
        int st;
        int rel;
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        st    = cyc + 1;
        q_a.push_back('{ep, ee, ef, 25, st});
        for (int i = 0; i < 100 && q_a.size() != 0; i++) begin
            @(negedge clk);
            rel   = cyc - st;
            start = (rel == pulse_rel);
            if (chk_drv && rel > 0 && rel <= 24 && (rel % 6 == 3 || rel % 6 == 0))
                chk("a_drv_pair", int'({drv1_a, drv0_a}),
                    (rel % 6 == 3) ? rel / 6 : rel / 6 - 1);
        end
        start = 1'b0;
        if (q_a.size() != 0) begin
            chk("a_done_timeout", 0, 1);
            q_a.delete();
        end
        chk("a_done_drv_idle", int'({drv1_a, drv0_a}), 0);
        chk("a_done_busy", int'(busy_a), 0);
    endtask

    initial begin
        int st;
        rst     = 1'b1;
        rst_b   = 1'b1;
        start   = 1'b0;
        start_b = 1'b0;
        mode    = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs_a", int'({busy_a, done_a, pass_a, err_a, fv_a, drv1_a, drv0_a}), 0);
        chk("reset_outputs_b", int'({busy_b, done_b, pass_b, err_b, fv_b, drv1_b, drv0_b}), 0);
        rst   = 1'b0;
        rst_b = 1'b0;

        // Instance B: 40 vectors, 30 mismatches, counter pinned at 15.
        @(negedge clk);
        start_b = 1'b1;
        q_b.push_back('{1'b0, 15, 4'b0111, 241, cyc + 1});
        @(negedge clk);
        start_b = 1'b0;

        run_a(0, 1'b1, 0, 4'b0000, 1'b1, -1);
        run_a(1, 1'b0, 1, 4'b1000, 1'b0, -1);
        run_a(2, 1'b0, 3, 4'b0111, 1'b0, -1);
        run_a(3, 1'b0, 2, 4'b0110, 1'b0, -1);

        // Abort a run with reset during the settle window of vector 2.
        @(negedge clk);
        mode  = 0;
        start = 1'b1;
        st    = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50 && (cyc - st) < 14; i++) @(negedge clk);
        chk("abort_busy_before_rst", int'(busy_a), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs_zero", int'({busy_a, done_a, pass_a, err_a, fv_a, drv1_a, drv0_a}), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_stays_idle", int'({busy_a, done_a, drv1_a, drv0_a}), 0);

        run_a(0, 1'b1, 0, 4'b0000, 1'b0, 5);

        for (int i = 0; i < 400 && q_b.size() != 0; i++) @(negedge clk);
        if (q_b.size() != 0) chk("b_done_timeout", 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/and_gate_selftest.md
Name: and_gate_selftest

Overview:
- On-board stimulus/checker for the two-input AND test gate.
- Drives the gate's two inputs through all four combinations and waits a settle window after each.
- Samples the gate output back through a synchronizer and compares it against the expected AND result.
- Reports pass/fail, an error count and a per-vector failure map for board LEDs. Sits in the board top beside the gate under test, wired through pins or a fabric loopback.

Parameters:
- SETTLE_CYCLES, 4: cycles waited after driving a vector before sampling. Legal minimum 3, which covers the 2-flop synchronizer.
- LOOPS, 1: number of full 4-vector sweeps per run. Legal range 1..255.
- ERR_W, 8: width of the error counter. The counter saturates at its maximum.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: level-sampled run request. Acted on only in IDLE or DONE.
- drv_in0, output, 1: stimulus to gate input in0, registered.
- drv_in1, output, 1: stimulus to gate input in1, registered.
- dut_out, input, 1: gate output, asynchronous to clk.
- busy, output, 1: high while a run is in progress.
- done, output, 1: high in DONE until the next start or reset.
- pass, output, 1: valid when done=1. 1 if err_count==0.
- err_count, output, ERR_W: total mismatches in the run, saturating.
- fail_vec, output, 4: bit v set if vector v mismatched in any sweep.

Behaviour:
- Reset: all outputs 0; state IDLE; vector index, loop count, settle count and synchronizer flops cleared. Reset is synchronous and active-high on clk, and a reset mid-run aborts to IDLE with nothing retained.
- Vector encoding: vector v in 0..3 gives {drv_in1, drv_in0} = v. Expected output = v[1] & v[0], so only vector 3 expects 1.
- dut_out passes through a 2-flop synchronizer. Comparisons use the second flop only.
- State IDLE: busy=0. If start=1: go to DRIVE; clear err_count, fail_vec, done and pass; vec=0; loop=0; busy=1 from the next cycle.
- State DRIVE (1 cycle): register drv_in from vec; clear the settle counter; go to SETTLE.
- State SETTLE: increment the counter each cycle. When counter == SETTLE_CYCLES-1, go to SAMPLE.
- State SAMPLE (1 cycle): compare the synchronized output to the expected value.
  - On mismatch: set fail_vec[vec]; err_count+1 unless already all-ones.
  - If vec<3: vec+1, go to DRIVE.
  - Else if loop<LOOPS-1: loop+1, vec=0, go to DRIVE.
  - Else go to DONE.
- State DONE: busy=0, done=1, pass=(err_count==0), drv_in0=drv_in1=0. err_count and fail_vec hold. If start=1, begin a new run exactly as from IDLE.
- Timing: each vector takes 2+SETTLE_CYCLES cycles. With start sampled high at edge 0, done rises at edge 4*LOOPS*(2+SETTLE_CYCLES)+1. Defaults give edge 25.
- start is ignored while busy=1. A held start in DONE restarts immediately, giving back-to-back runs.
- drv_in outputs change only on entry to DRIVE, on entry to DONE, or on reset. No glitching between vectors.
- Saturation: err_count never wraps. fail_vec is a sticky OR across loops.

Test Plan:
- Correct AND model on dut_out, defaults, start pulse at edge 0: drv pairs 00,01,10,11 each held 6 cycles; done=1 at edge 25; pass=1; err_count=0; fail_vec=0000.
- dut_out stuck at 0: fail_vec=1000, err_count=1, pass=0.
- dut_out stuck at 1: fail_vec=0111, err_count=3, pass=0.
- OR-gate model on dut_out: fail_vec=0110, err_count=2, pass=0.
- ERR_W=4, LOOPS=10, stuck-at-1: err_count saturates at 15 and does not wrap to 14; fail_vec=0111.
- rst asserted in SETTLE of vector 2: next cycle all outputs 0 and state IDLE. Pulsing start while busy is ignored; a new start afterwards yields a full clean run with done at edge 25 relative to that start.
